// File: rtl/hall_period_meter.sv
// Hall-sensor period meter: measures edge-to-edge rotor time in prescaled ticks
// and reports direction, stall, and illegal hall sequences.
module hall_period_meter #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 4,
  parameter int TIMEOUT  = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       hall_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             dir,
  output logic             stalled,
  output logic             hall_fault
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0]  PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  state_t           state;
  logic [2:0]       sync1, sync2, prev;
  logic [PS_W-1:0]  ps_cnt;
  logic [CNT_W-1:0] tick_cnt;

  // Position in the forward sequence 101,100,110,010,011,001; 7 marks an illegal code.
  function automatic logic [2:0] seq_pos(input logic [2:0] code);
    case (code)
      3'b101:  seq_pos = 3'd0;
      3'b100:  seq_pos = 3'd1;
      3'b110:  seq_pos = 3'd2;
      3'b010:  seq_pos = 3'd3;
      3'b011:  seq_pos = 3'd4;
      3'b001:  seq_pos = 3'd5;
      default: seq_pos = 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] next_pos(input logic [2:0] p);
    next_pos = (p == 3'd5) ? 3'd0 : 3'(p + 3'd1);
  endfunction

  logic [2:0]       pos_new, pos_prev;
  logic             edge_det, ill_new, ill_prev, fwd, rev;
  logic             accepted, bad_jump, illegal_hit, tick, timeout_hit;
  logic [CNT_W-1:0] capture;

  always_comb begin
    pos_new     = seq_pos(sync2);
    pos_prev    = seq_pos(prev);
    edge_det    = (sync2 != prev);
    ill_new     = (pos_new == 3'd7);
    ill_prev    = (pos_prev == 3'd7);
    fwd         = (next_pos(pos_prev) == pos_new);
    rev         = (next_pos(pos_new) == pos_prev);
    accepted    = edge_det && !ill_new && !ill_prev && (fwd || rev);
    bad_jump    = edge_det && !ill_new && !accepted;
    illegal_hit = edge_det && ill_new;
    tick        = (ps_cnt == PS_MAX);
    timeout_hit = (tick_cnt == TO_VAL);
    // The tick landing in the edge cycle itself still counts toward this interval.
    capture     = (tick && tick_cnt != '1) ? tick_cnt + CNT_W'(1) : tick_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      sync1        <= '0;
      sync2        <= '0;
      prev         <= '0;
      ps_cnt       <= '0;
      tick_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      dir          <= 1'b0;
      stalled      <= 1'b0;
      hall_fault   <= 1'b0;
    end else begin
      sync1        <= hall_in;
      sync2        <= sync1;
      prev         <= sync2;
      period_valid <= 1'b0;
      hall_fault   <= 1'b0;
      if (!enable) begin
        state    <= IDLE;
        stalled  <= 1'b0;
        ps_cnt   <= '0;
        tick_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ARM;
            ps_cnt   <= '0;
            tick_cnt <= '0;
          end
          ARM, MEASURE: begin
            hall_fault <= illegal_hit || bad_jump;
            // Priority: accepted edge, then bad jump, then timeout, then plain counting.
            if (accepted) begin
              dir      <= fwd;
              stalled  <= 1'b0;
              ps_cnt   <= '0;
              tick_cnt <= '0;
              if (state == MEASURE) begin
                period       <= capture;
                period_valid <= 1'b1;
              end
              state <= MEASURE;
            end else if (bad_jump) begin
              ps_cnt   <= '0;
              tick_cnt <= '0;
              state    <= ARM;
            end else if (timeout_hit) begin
              stalled  <= 1'b1;
              period   <= '1;
              ps_cnt   <= '0;
              tick_cnt <= '0;
              state    <= ARM;
            end else begin
              ps_cnt <= tick ? '0 : ps_cnt + PS_W'(1);
              if (tick && tick_cnt != '1)
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/hall_period_meter.md
Name: hall_period_meter

Overview:
Measures BLDC rotor speed as the time between hall-sensor transitions. It is the counterpart of the clock divider: the divider turns clk into a slower frequency, and this block turns an external frequency back into a count. It uses an internal prescaler matching the 6.25 MHz ESC tick (clk/4). The block also reports rotation direction, stall, and illegal hall sequences to the PID controller.

Parameters:
CNT_W, 16, width of period counter and period output
PRESCALE, 4, clk cycles per period tick (clk/4 = 6.25 MHz ESC tick); must be >= 2
TIMEOUT, 50000, tick count at which the rotor is declared stalled; must be < 2^CNT_W

Ports:
clk  input  1  system clock (25 MHz)
rst  input  1  reset, synchronous, active-high
enable  input  1  measurement enable; 0 forces IDLE
hall_in  input  3  asynchronous hall sensor inputs {A,B,C}
period  output  CNT_W  last measured edge-to-edge time in ticks
period_valid  output  1  one-cycle strobe when period is updated
dir  output  1  1 = forward, 0 = reverse; last legal transition
stalled  output  1  high while no edge has arrived within TIMEOUT ticks
hall_fault  output  1  one-cycle strobe on an illegal code or a non-adjacent transition

Behaviour:
- Reset: all of the following are 0: period, period_valid, dir, stalled, hall_fault, synchronizer flops, previous-code register, prescaler, tick counter. State goes to IDLE.
- Input synchronization: 2-flop synchronizer on hall_in, then a registered previous code (prev).
- Edge detection: an edge is sync2 != prev. prev <= sync2 every cycle.
- Legal codes: 000 and 111 are illegal. A code equal to 000 or 111 that differs from prev pulses hall_fault and is otherwise ignored; prev still updates.
- Forward sequence: 101 -> 100 -> 110 -> 010 -> 011 -> 001 -> 101. The reverse direction is the same sequence backwards.
- Accepted edge: prev is legal, the new code is legal, and the codes are adjacent in the sequence. dir is set accordingly.
- Non-adjacent legal transition (including one from an illegal prev): pulse hall_fault, leave dir unchanged, clear counters, go to ARM with no period_valid.
- Prescaler: counts 0..PRESCALE-1; a tick occurs when it is at PRESCALE-1 (then it wraps to 0). Both the prescaler and the tick counter are cleared on every accepted edge and on entry to ARM.
- Tick counter: increments on tick and saturates at all-ones.
- Latency: a hall_in change sampled at clk edge N appears as period_valid in cycle N+3.
- period value: equals floor(D/PRESCALE), where D is the number of clk cycles between two accepted edges.
- State machine:
  - IDLE: counters held at 0, stalled = 0. Leave to ARM when enable = 1.
  - ARM: wait for the first accepted edge. Counting runs so that a stall is still detected. On an accepted edge go to MEASURE with no period_valid, because the first interval is partial.
  - MEASURE: on an accepted edge, period <= tick counter, pulse period_valid, clear counters, stalled <= 0.
  - Stall (ARM or MEASURE): when tick counter == TIMEOUT, stalled <= 1, period <= all-ones, no period_valid, clear counters, go to ARM.
  - stalled clears on the next accepted edge.
- enable = 0 in any state: go to IDLE next cycle. period and dir hold, stalled <= 0, and no strobes are generated.
- Simultaneous accepted edge and timeout in the same cycle: the edge wins. Normal MEASURE update, stalled not set.
- Simultaneous edge and enable falling: enable wins, no strobe.
- rst asserted mid-operation: everything returns to reset values on the next clk edge, regardless of state.
- Strobes are always single-cycle and registered. Outputs never glitch combinationally.

Test Plan:
- rst held 3 cycles with hall_in toggling -> all outputs 0; state IDLE; no strobes.
- enable=1; forward sequence 101,100,110,010 with 400 clk spacing, PRESCALE=4 -> first edge gives no strobe; then period=100 with dir=1 and period_valid on each later edge, asserted 3 clk after the pin change.
- Reverse sequence 101,001,011 at 800 clk spacing -> period=200, dir=0.
- TIMEOUT=50 with hall_in held after a valid edge -> stalled=1 after 50 ticks (200 clk), period=0xFFFF, no period_valid. The next two adjacent edges -> stalled=0 on the first and period valid on the second.
- Inject 111, then a jump 101->010 -> hall_fault pulses once per event, no period_valid, dir unchanged, counters restart.
- Edge arriving in the exact cycle the tick counter hits TIMEOUT -> period_valid with period=TIMEOUT, stalled stays 0. Deassert enable mid-MEASURE -> IDLE, period held, no strobes.
